// File: rtl/spi_req_arbiter_pkg.sv
// Shared constants and state encoding for the SPI request arbiter.
// The width defaults are common to the arbiter and the SPI master it feeds.
package spi_req_arbiter_pkg;

    localparam int SPI_A_WIDTH  = 8;
    localparam int SPI_D_WIDTH  = 16;
    localparam int ARB_N_REQ    = 4;
    localparam int ARB_START_TO = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        FINISH  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// Round-robin priority pick: one-hot select of the first set request found
// when searching upward from index ptr, wrapping modulo N_REQ.
module rr_pick
    import spi_req_arbiter_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] sel
);

    logic found;

    // For each search distance from ptr, take the requester at that distance
    // if nothing closer was already taken.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int d = 0; d < N_REQ; d++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (((j + N_REQ - int'(ptr)) % N_REQ) == d)) begin
                    sel[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Arbitrates N_REQ requesters onto a single SPI master, one transaction at
// a time, with a start timeout in case the master never drops chip select.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; grant the round-robin winner when m_cs is high
// LAUNCH  | operands registered; m_start pulses for this one cycle
// WAIT_LO | waiting for m_cs to fall; timeout raises err and returns idle
// WAIT_HI | transfer in progress; waiting for m_cs to rise again
// FINISH  | done pulse for the granted requester; read data already loaded
module spi_req_arbiter
    import spi_req_arbiter_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ,
    parameter int A_WIDTH  = SPI_A_WIDTH,
    parameter int D_WIDTH  = SPI_D_WIDTH,
    parameter int START_TO = ARB_START_TO
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           req_rw,
    input  logic [N_REQ*A_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*D_WIDTH-1:0]   req_wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic [D_WIDTH-1:0]         rdata,
    output logic                       err,
    output logic                       m_start,
    output logic                       m_r_w,
    output logic [A_WIDTH-1:0]         m_addr,
    output logic [D_WIDTH-1:0]         m_wdata,
    input  logic                       m_cs,
    input  logic [D_WIDTH-1:0]         m_rdata
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (START_TO > 1) ? $clog2(START_TO) : 1;

    arb_state_t         state, state_nxt;
    logic [PW-1:0]      ptr, ptr_nxt;
    logic [N_REQ-1:0]   sel, gsel;
    logic [TW-1:0]      to_cnt;
    logic               launch, timeout, rd_load;
    logic               sel_rw;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_wdata;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .sel (sel)
    );

    // gnt is decided in the IDLE cycle itself and is forced low while rst is
    // held, since requests may already be high during reset.
    assign gnt = sel & {N_REQ{launch & ~rst}};

    // Operands of the winner and the pointer value that follows it.
    always_comb begin
        ptr_nxt   = ptr;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel[k]) begin
                ptr_nxt   = PW'((k + 1) % N_REQ);
                sel_rw    = req_rw[k];
                sel_addr  = req_addr[k*A_WIDTH +: A_WIDTH];
                sel_wdata = req_wdata[k*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // Next-state logic and the state-decoded strobes.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        timeout   = 1'b0;
        rd_load   = 1'b0;
        m_start   = 1'b0;
        done      = '0;
        case (state)
            IDLE: begin
                if ((req != '0) && m_cs) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                m_start   = 1'b1;
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!m_cs) begin
                    state_nxt = WAIT_HI;
                end else if (to_cnt == TW'(START_TO - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_HI: begin
                if (m_cs) begin
                    rd_load   = m_r_w;
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = gsel;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture pointer, granted requester and operands on each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            gsel    <= '0;
            m_r_w   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (launch) begin
            ptr     <= ptr_nxt;
            gsel    <= sel;
            m_r_w   <= sel_rw;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
        end
    end

    // Start timeout: cleared in LAUNCH, counts the cycles spent in WAIT_LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    to_cnt <= '0;
        else if (state == LAUNCH)   to_cnt <= '0;
        else if (state == WAIT_LO)  to_cnt <= to_cnt + 1'b1;
    end

    // err pulses in the first IDLE cycle after a start timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= timeout;
    end

    // Read data is loaded as m_cs rises so it is valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rdata <= '0;
        else if (rd_load) rdata <= m_rdata;
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: a simple SPI master model, a transaction-level
// reference checked every cycle, and directed scenarios with literal checks.
module tb_spi_req_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int STO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rdata;
    logic            err, m_start, m_r_w;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_cs;
    logic [DW-1:0]   m_rdata;

    spi_req_arbiter #(.N_REQ(N), .A_WIDTH(AW), .D_WIDTH(DW), .START_TO(STO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .m_start(m_start), .m_r_w(m_r_w), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_cs(m_cs), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (((r >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (((v >> k) & 4'd1) != 4'd0) return k;
        return -1;
    endfunction

    // ---------------- SPI master model ----------------
    // Takes m_start, drops cs on the following cycle, holds it low for
    // xfer_len cycles. When stuck, it ignores m_start entirely.
    int xfer_len = 4;
    bit stuck    = 1'b0;
    bit pend     = 1'b0;
    int mcnt     = 0;

    initial begin
        m_cs = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_cs = 1'b1; pend = 1'b0; mcnt = 0;
            end else begin
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) m_cs = 1'b1;
                end else if (pend) begin
                    pend = 1'b0; m_cs = 1'b0; mcnt = xfer_len;
                end
                if (m_start && !stuck) pend = 1'b1;
            end
        end
    end

    // ---------------- reference model state ----------------
    bit            busy = 1'b0;
    int            ptr_m = 0, g_cyc = 0, g_idx = 0, low_cyc = -1, rel_cyc = -1, err_cyc = -1;
    logic          exp_rw = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0, exp_rdata = '0;

    // ---------------- observation log ----------------
    int            gnt_cnt = 0, done_cnt = 0, err_cnt = 0;
    int            last_gnt_cyc = 0, last_start_cyc = 0, last_done_cyc = 0, last_err_cyc = 0;
    int            last_gnt_idx = -1, last_done_idx = -1, lo_obs = 0;
    logic [AW-1:0] start_addr = '0;
    logic [DW-1:0] start_wdata = '0, done_rdata = '0;
    logic          start_rw = 1'b0;
    bit            out_flag = 1'b0, overlap = 1'b0;
    int            gnt_log[$];

    // Compare process: mid-cycle, every cycle.
    always @(negedge clk) begin : compare
        logic [N-1:0] e_gnt, e_done;
        logic         e_err, e_start;
        bit           grant_now, finish_now, tmo_now, cap_rd;
        int           gi;
        cyc++;
        if (rst) begin
            chk("rst_gnt", gnt, 0);     chk("rst_done", done, 0);
            chk("rst_err", err, 0);     chk("rst_m_start", m_start, 0);
            chk("rst_rdata", rdata, 0); chk("rst_m_addr", m_addr, 0);
            chk("rst_m_wdata", m_wdata, 0); chk("rst_m_r_w", m_r_w, 0);
            busy = 1'b0; ptr_m = 0; err_cyc = -1;
            exp_rw = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
            out_flag = 1'b0;
        end else begin
            e_gnt = '0; e_done = '0; e_start = 1'b0;
            e_err = (cyc == err_cyc);
            grant_now = 0; finish_now = 0; tmo_now = 0; cap_rd = 0; gi = -1;
            if (!busy) begin
                if (req != '0 && m_cs) begin
                    gi = rr_model(req, ptr_m);
                    e_gnt = 4'(1) << gi;
                    grant_now = 1;
                end
            end else if (cyc == g_cyc + 1) begin
                e_start = 1'b1;
            end else if (low_cyc < 0) begin
                if (!m_cs) low_cyc = cyc;
                else if (cyc == g_cyc + 1 + STO) begin
                    tmo_now = 1; err_cyc = cyc + 1;
                end
            end else if (rel_cyc < 0) begin
                if (m_cs) begin rel_cyc = cyc; cap_rd = 1; end
            end else if (cyc == rel_cyc + 1) begin
                e_done = 4'(1) << g_idx;
                finish_now = 1;
            end

            chk("gnt", gnt, e_gnt);           chk("done", done, e_done);
            chk("err", err, e_err);           chk("m_start", m_start, e_start);
            chk("m_r_w", m_r_w, exp_rw);      chk("m_addr", m_addr, exp_addr);
            chk("m_wdata", m_wdata, exp_wdata); chk("rdata", rdata, exp_rdata);

            if (finish_now || tmo_now) busy = 1'b0;
            if (cap_rd && exp_rw) exp_rdata = m_rdata;
            if (grant_now) begin
                busy = 1'b1; g_cyc = cyc; g_idx = gi; low_cyc = -1; rel_cyc = -1;
                ptr_m     = (gi + 1) % N;
                exp_rw    = 1'((req_rw >> gi) & 4'd1);
                exp_addr  = AW'(req_addr >> (gi * AW));
                exp_wdata = DW'(req_wdata >> (gi * DW));
            end

            // log what the DUT did
            if (done != '0) begin
                done_cnt++; last_done_cyc = cyc; last_done_idx = oh_idx(done);
                done_rdata = rdata; out_flag = 1'b0;
                chk("latency", cyc - last_gnt_cyc, lo_obs + 3);
            end
            if (err) begin
                err_cnt++; last_err_cyc = cyc; out_flag = 1'b0;
            end
            if (gnt != '0) begin
                if (out_flag) overlap = 1'b1;
                out_flag = 1'b1;
                gnt_cnt++; last_gnt_cyc = cyc; last_gnt_idx = oh_idx(gnt);
                gnt_log.push_back(last_gnt_idx);
                lo_obs = 0;
            end else if (!m_cs) begin
                lo_obs++;
            end
            if (m_start) begin
                last_start_cyc = cyc; start_addr = m_addr; start_wdata = m_wdata; start_rw = m_r_w;
            end
        end
    end

    function automatic int cnt_sel(input int which);
        case (which)
            0:       return gnt_cnt;
            1:       return done_cnt;
            default: return done_cnt + err_cnt;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string nm);
        int n = 0;
        while (cnt_sel(which) < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (cnt_sel(which) < target) chk(nm, cnt_sel(which), target);
    endtask

    task automatic set_ops(input int i, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [N*AW-1:0] ma, va;
        logic [N*DW-1:0] md, vd;
        logic [N-1:0]    one;
        ma = '0; ma[AW-1:0] = '1; va = '0; va[AW-1:0] = a;
        md = '0; md[DW-1:0] = '1; vd = '0; vd[DW-1:0] = d;
        one = 1;
        req_addr  = (req_addr  & ~(ma << (i * AW))) | (va << (i * AW));
        req_wdata = (req_wdata & ~(md << (i * DW))) | (vd << (i * DW));
        req_rw    = rw ? (req_rw | (one << i)) : (req_rw & ~(one << i));
    endtask

    task automatic run_one(input int i, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int g0, e0;
        logic [N-1:0] one;
        one = 1;
        set_ops(i, rw, a, d);
        g0 = gnt_cnt; e0 = done_cnt + err_cnt;
        req = req | (one << i);
        wait_for(0, g0 + 1, 50, "wait_gnt");
        req = req & ~(one << i);
        wait_for(2, e0 + 1, 100, "wait_end");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, e0, g0;
        logic [N-1:0] one;
        one = 1;
        rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0; m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_gnt", gnt, 0); chk("init_m_addr", m_addr, 0); chk("init_rdata", rdata, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single write from requester 2
        xfer_len = 4;
        run_one(2, 1'b0, 8'h3C, 16'hA55A);
        chk("s1_gnt_idx", last_gnt_idx, 2);
        chk("s1_start_lat", last_start_cyc - last_gnt_cyc, 1);
        chk("s1_addr", start_addr, 8'h3C);
        chk("s1_wdata", start_wdata, 16'hA55A);
        chk("s1_rw", start_rw, 0);
        chk("s1_done_idx", last_done_idx, 2);
        chk("s1_done_lat", last_done_cyc - last_gnt_cyc, 7);

        // single read from requester 1
        m_rdata = 16'hBEEF; xfer_len = 3;
        run_one(1, 1'b1, 8'h10, 16'h0000);
        chk("s2_gnt_idx", last_gnt_idx, 1);
        chk("s2_done_idx", last_done_idx, 1);
        chk("s2_done_rdata", done_rdata, 16'hBEEF);
        chk("s2_done_lat", last_done_cyc - last_gnt_cyc, 6);
        m_rdata = 16'h1234;
        repeat (5) @(posedge clk);
        #1;
        chk("s2_rdata_hold", rdata, 16'hBEEF);

        // all four requesters held from reset
        rst = 1'b1; xfer_len = 2; m_rdata = 16'h0F0F;
        for (int i = 0; i < N; i++) set_ops(i, (i % 2) == 1, AW'(8'h80 + i), DW'(16'h1000 * (i + 1)));
        req = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("s3_rst_gnt", gnt, 0);
        gnt_log.delete(); overlap = 1'b0;
        g0 = gnt_cnt; e0 = done_cnt + err_cnt;
        rst = 1'b0;
        wait_for(0, g0 + 5, 200, "s3_wait_gnt");
        req = '0;
        wait_for(2, e0 + 5, 100, "s3_wait_end");
        chk("s3_count", gnt_log.size(), 5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("s3_order", gnt_log[k], k % N);
        chk("s3_overlap", overlap, 0);
        repeat (2) @(posedge clk);
        #1;

        // stuck master, then a normal request
        stuck = 1'b1; d0 = done_cnt;
        run_one(3, 1'b0, 8'h77, 16'h1111);
        chk("s4_gnt_idx", last_gnt_idx, 3);
        chk("s4_err_lat", last_err_cyc - last_start_cyc, STO + 1);
        chk("s4_no_done", done_cnt, d0);
        stuck = 1'b0; xfer_len = 2;
        run_one(0, 1'b0, 8'h01, 16'h2222);
        chk("s4_next_idx", last_done_idx, 0);
        chk("s4_next_done", done_cnt, d0 + 1);

        // reset during the transfer
        xfer_len = 6; m_rdata = 16'h7777;
        set_ops(2, 1'b1, 8'h55, 16'h4444);
        g0 = gnt_cnt;
        req = req | (one << 2);
        wait_for(0, g0 + 1, 50, "s5_wait_gnt");
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("s5_gnt", gnt, 0);         chk("s5_done", done, 0);
        chk("s5_err", err, 0);         chk("s5_m_start", m_start, 0);
        chk("s5_rdata", rdata, 0);     chk("s5_m_addr", m_addr, 0);
        chk("s5_m_wdata", m_wdata, 0); chk("s5_m_r_w", m_r_w, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("s5_no_done", done_cnt, d0);
        xfer_len = 2;
        run_one(0, 1'b0, 8'h5A, 16'h3333);
        chk("s5_gnt_idx", last_gnt_idx, 0);
        chk("s5_done_idx", last_done_idx, 0);
        chk("s5_done_cnt", done_cnt, d0 + 1);
        chk("s5_rdata_after", rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
